muldiv_sched: RTL and testbench

Round-robin scheduler that shares the single multi-cycle multiply/divide unit (`alu_muldiv`, reached through the ALU MULDIV section) between N requesters, for example the main pipeline and an auxiliary lane. It accepts requests over valid/ready handshakes and holds operands stable on the unit for the whole operation. It captures the result on completion and returns it over a per-requester response handshake. It also supports per-requester flush, which discards in-flight work.

---
 rtl/muldiv_sched_pkg.sv | 29 ++
 rtl/muldiv_sched_rr_arbiter.sv | 35 +++
 rtl/muldiv_sched.sv | 142 ++++++++++++++
 tb/tb_muldiv_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sched_pkg
// Description : Muldiv op encodings and scheduler state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_sched_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 32;

  // Muldiv op codes, shared with the ALU MULDIV section
  localparam logic [OP_W-1:0] OP_MUL    = 3'b000;
  localparam logic [OP_W-1:0] OP_MULH   = 3'b001;
  localparam logic [OP_W-1:0] OP_MULHSU = 3'b010;
  localparam logic [OP_W-1:0] OP_MULHU  = 3'b011;
  localparam logic [OP_W-1:0] OP_DIV    = 3'b100;
  localparam logic [OP_W-1:0] OP_DIVU   = 3'b101;
  localparam logic [OP_W-1:0] OP_REM    = 3'b110;
  localparam logic [OP_W-1:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; searches from ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PTR_W = $clog2(N);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    // Offsets 1..N visit every requester once, ending at the last grant
    for (int i = 1; i <= N; i++) begin
      w_idx = PTR_W'((int'(ptr) + i) % N);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sched
// Description : Round-robin sharing of one multi-cycle muldiv unit among N_REQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [OP_W*N_REQ-1:0]   req_op_i,
  input  logic [DATA_W*N_REQ-1:0] req_num1_i,
  input  logic [DATA_W*N_REQ-1:0] req_num2_i,
  input  logic [N_REQ-1:0]        flush_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  input  logic [N_REQ-1:0]        rsp_ready_i,
  output logic [DATA_W-1:0]       rsp_result_o,
  output logic [OP_W-1:0]         md_op_o,
  output logic                    md_valid_o,
  output logic [DATA_W-1:0]       md_num1_o,
  output logic [DATA_W-1:0]       md_num2_o,
  input  logic                    md_busy_i,
  input  logic [DATA_W-1:0]       md_result_i,
  output logic                    busy_o
);

  localparam int PTR_W = $clog2(N_REQ);

  sched_state_e      r_state, w_state_nxt;
  logic [PTR_W-1:0]  r_ptr, r_owner, w_sel_idx;
  logic [OP_W-1:0]   r_op, w_sel_op;
  logic [DATA_W-1:0] r_num1, r_num2, r_result, w_sel_num1, w_sel_num2;
  logic              r_md_valid, r_kill, r_first;
  logic [N_REQ-1:0]  w_req, w_grant, w_owner_oh;
  logic              w_hs, w_done, w_owner_flush;

  // A requester flushing in the same cycle is not eligible for a grant
  assign w_req = req_valid_i & ~flush_i;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  always_comb begin
    w_sel_idx  = '0;
    w_sel_op   = '0;
    w_sel_num1 = '0;
    w_sel_num2 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_idx  = PTR_W'(i);
        w_sel_op   = req_op_i[i*OP_W +: OP_W];
        w_sel_num1 = req_num1_i[i*DATA_W +: DATA_W];
        w_sel_num2 = req_num2_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_owner_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_owner_oh[i] = (PTR_W'(i) == r_owner);
    end
  end

  assign w_owner_flush = flush_i[r_owner];
  assign w_hs          = (r_state == ST_IDLE) && (|w_grant);
  // The unit already reports busy in the entry cycle, so that cycle is skipped
  assign w_done        = (r_state == ST_RUN) && !r_first && !md_busy_i;

  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = '0;
    rsp_valid_o = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = w_grant;
        if (w_hs) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_done) w_state_nxt = (r_kill || w_owner_flush) ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = w_owner_oh;
        if (rsp_ready_i[r_owner] || w_owner_flush) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr      <= PTR_W'(N_REQ - 1);
      r_owner    <= '0;
      r_op       <= '0;
      r_num1     <= '0;
      r_num2     <= '0;
      r_result   <= '0;
      r_md_valid <= 1'b0;
      r_kill     <= 1'b0;
      r_first    <= 1'b0;
    end else begin
      r_first <= w_hs;
      if (w_hs) begin
        r_ptr      <= w_sel_idx;
        r_owner    <= w_sel_idx;
        r_op       <= w_sel_op;
        r_num1     <= w_sel_num1;
        r_num2     <= w_sel_num2;
        r_md_valid <= 1'b1;
      end
      // Dropping valid right after completion keeps the unit from restarting
      if (w_done) begin
        r_result   <= md_result_i;
        r_md_valid <= 1'b0;
      end
      if (w_state_nxt == ST_IDLE)                    r_kill <= 1'b0;
      else if (r_state == ST_RUN && w_owner_flush)   r_kill <= 1'b1;
    end
  end

  assign md_valid_o   = r_md_valid;
  assign md_op_o      = r_op;
  assign md_num1_o    = r_num1;
  assign md_num2_o    = r_num2;
  assign rsp_result_o = r_result;
  assign busy_o       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sched
// Description : Directed self-checking bench for muldiv_sched with a muldiv unit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sched;
  import muldiv_sched_pkg::*;

  localparam int DIV_LAT = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, flush, rsp_valid, rsp_ready;
  logic [5:0]  req_op;
  logic [63:0] req_num1, req_num2;
  logic [31:0] rsp_result, md_num1, md_num2, md_result;
  logic [2:0]  md_op;
  logic        md_valid, md_busy, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_sched #(.N_REQ(2)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_num1_i(req_num1), .req_num2_i(req_num2), .flush_i(flush),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .md_op_o(md_op), .md_valid_o(md_valid), .md_num1_o(md_num1), .md_num2_o(md_num2),
    .md_busy_i(md_busy), .md_result_i(md_result), .busy_o(busy)
  );

  // Muldiv unit model: IDLE (busy follows input_valid), BUSY, FINISH (busy=0)
  logic [1:0]  u_st;
  int          u_left;
  logic [2:0]  u_op;
  logic [31:0] u_a, u_b, u_res;

  function automatic logic [31:0] unit_calc(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic [31:0] r;
    ea = {{32{(op == OP_MULH || op == OP_MULHSU) & a[31]}}, a};
    eb = {{32{(op == OP_MULH) & b[31]}}, b};
    p  = ea * eb;
    r  = p[63:32];
    case (op)
      OP_MUL:  r = p[31:0];
      OP_DIV:  if (b == 0) r = 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
               else r = $signed(a) / $signed(b);
      OP_DIVU: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
      OP_REM:  if (b == 0) r = a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
               else r = $signed(a) % $signed(b);
      OP_REMU: if (b == 0) r = a; else r = a % b;
      default: r = p[63:32];
    endcase
    return r;
  endfunction

  assign md_busy   = (u_st == 2'd0) ? md_valid : (u_st == 2'd1);
  assign md_result = u_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_st <= 2'd0; u_left <= 0; u_op <= '0; u_a <= '0; u_b <= '0; u_res <= '0;
    end else begin
      case (u_st)
        2'd0: if (md_valid) begin
          u_op <= md_op; u_a <= md_num1; u_b <= md_num2;
          u_left <= md_op[2] ? DIV_LAT : 4;
          u_st <= 2'd1;
        end
        2'd1: if (u_left == 1) begin
          u_st  <= 2'd2;
          u_res <= unit_calc(u_op, u_a, u_b);
        end else u_left <= u_left - 1;
        default: u_st <= 2'd0;
      endcase
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_req(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[idx*3 +: 3]    = op;
    req_num1[idx*32 +: 32] = a;
    req_num2[idx*32 +: 32] = b;
    req_valid[idx]         = 1'b1;
  endtask

  // Called at posedge+1; returns at E0+1 with waited = IDLE cycles spent, -1 on timeout
  task automatic issue(input int idx, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int waited);
    int  c;
    bit  got;
    c = 0; got = 0;
    set_req(idx, op, a, b);
    while (!got && c < 50) begin
      #1;
      if (req_ready[idx]) got = 1;
      else begin @(posedge clk); #1; c++; end
    end
    if (got) begin @(posedge clk); #1; waited = c; end
    else waited = -1;
    req_valid[idx] = 1'b0;
  endtask

  // Counts cycles from the accept cycle (E0+1 is cycle 1); -1 on timeout
  task automatic wait_rsp(input int idx, output int cyc);
    cyc = 1;
    while (!rsp_valid[idx] && cyc < 60) begin @(posedge clk); #1; cyc++; end
    if (!rsp_valid[idx]) cyc = -1;
  endtask

  task automatic consume(input int idx);
    rsp_ready[idx] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[idx] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 0; req_valid = '0; flush = '0; rsp_ready = '0;
    req_op = '0; req_num1 = '0; req_num2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    n_checks++; if (rsp_result !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
    n_checks++; if (md_valid !== 1'b0) begin n_fail++; $display("FAIL reset_md_valid: got %b expected 0", md_valid); end
    n_checks++; if ({md_op, md_num1, md_num2} !== 67'd0) begin n_fail++; $display("FAIL reset_md_operands: got %h expected 0", {md_op, md_num1, md_num2}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1;
    // Same-requester request and flush in IDLE must not be granted
    req_valid[0] = 1'b1; flush[0] = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL flush_blocks_grant: got %b expected 00", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_busy: got %b expected 0", busy); end
    req_valid = '0; flush = '0;
  endtask

  task automatic test_single_mul;
    int w, cyc, stable_bad, ready_bad;
    issue(0, OP_MUL, 32'd7, 32'hFFFF_FFFD, w);
    n_checks++; if (w !== 0) begin n_fail++; $display("FAIL mul_accept_wait: got %0d expected 0", w); end
    cyc = 1; stable_bad = 0; ready_bad = 0;
    while (!rsp_valid[0] && cyc < 60) begin
      if (md_valid !== 1'b1 || md_op !== OP_MUL || md_num1 !== 32'd7 || md_num2 !== 32'hFFFF_FFFD) stable_bad++;
      if (req_ready !== 2'b00) ready_bad++;
      @(posedge clk); #1; cyc++;
    end
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL mul_latency: got %0d expected 7", cyc); end
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL mul_rsp_valid: got %b expected 01", rsp_valid); end
    n_checks++; if (rsp_result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h expected ffffffeb", rsp_result); end
    n_checks++; if (stable_bad !== 0) begin n_fail++; $display("FAIL mul_operands_stable: got %0d bad cycles expected 0", stable_bad); end
    n_checks++; if (ready_bad !== 0) begin n_fail++; $display("FAIL mul_ready_in_run: got %0d bad cycles expected 0", ready_bad); end
    n_checks++; if (md_valid !== 1'b0) begin n_fail++; $display("FAIL mul_md_valid_resp: got %b expected 0", md_valid); end
    consume(0);
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mul_after_consume: got busy=%b rsp=%b expected 0/00", busy, rsp_valid); end
  endtask

  task automatic test_contention;
    int g[4];
    int ng, rdy_bad, res_bad;
    ng = 0; rdy_bad = 0; res_bad = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    rsp_ready = 2'b11;
    set_req(0, OP_MUL, 32'd2, 32'd3);
    set_req(1, OP_MULHU, 32'h8000_0000, 32'd4);
    #1;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      if (req_ready !== 2'b00 && busy) rdy_bad++;
      if (rsp_valid === 2'b01 && rsp_result !== 32'd6) res_bad++;
      if (rsp_valid === 2'b10 && rsp_result !== 32'd2) res_bad++;
      if (req_ready === 2'b01) begin g[ng] = 0; ng++; end
      else if (req_ready === 2'b10) begin g[ng] = 1; ng++; end
      else if (req_ready !== 2'b00) begin g[ng] = 9; ng++; end
      if (ng < 4) begin @(posedge clk); #2; end
    end
    req_valid = '0; rsp_ready = '0;
    n_checks++; if (ng !== 4) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 4", ng); end
    for (int i = 0; i < ng; i++) begin
      n_checks++; if (g[i] !== (i % 2)) begin n_fail++; $display("FAIL rr_grant_%0d: got %0d expected %0d", i, g[i], i % 2); end
    end
    n_checks++; if (rdy_bad !== 0) begin n_fail++; $display("FAIL rr_ready_outside_idle: got %0d expected 0", rdy_bad); end
    n_checks++; if (res_bad !== 0) begin n_fail++; $display("FAIL rr_results: got %0d bad expected 0", res_bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int w, cyc;
    issue(0, OP_DIV, 32'd100, 32'd0, w);
    wait_rsp(0, cyc);
    n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL div0_timeout: got %0d expected response", cyc); end
    n_checks++; if (rsp_result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_quotient: got %h expected ffffffff", rsp_result); end
    n_checks++; if (md_valid !== 1'b0) begin n_fail++; $display("FAIL div0_md_valid_gap: got %b expected 0", md_valid); end
    consume(0);
    issue(0, OP_REM, 32'd100, 32'd0, w);
    wait_rsp(0, cyc);
    n_checks++; if (rsp_result !== 32'd100) begin n_fail++; $display("FAIL rem0_remainder: got %h expected 00000064", rsp_result); end
    consume(0);
  endtask

  task automatic test_flush_run;
    int w, k, rsp_seen, first_rdy, cyc;
    issue(0, OP_MUL, 32'd3, 32'd5, w);
    set_req(1, OP_MULHSU, 32'hFFFF_FFFF, 32'd2);
    k = 1; rsp_seen = 0; first_rdy = -1;
    while (first_rdy < 0 && k < 40) begin
      flush[0] = (k == 3);
      #1;
      if (rsp_valid !== 2'b00) rsp_seen++;
      if (req_ready[1] === 1'b1) first_rdy = k;
      else begin @(posedge clk); #1; k++; end
    end
    flush = '0;
    n_checks++; if (rsp_seen !== 0) begin n_fail++; $display("FAIL flush_no_rsp: got %0d rsp cycles expected 0", rsp_seen); end
    n_checks++; if (first_rdy !== 7) begin n_fail++; $display("FAIL flush_next_grant: got cycle %0d expected 7", first_rdy); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(1, cyc);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL flush_req1_latency: got %0d expected 7", cyc); end
    n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL flush_req1_rsp_valid: got %b expected 10", rsp_valid); end
    n_checks++; if (rsp_result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flush_req1_result: got %h expected ffffffff", rsp_result); end
    consume(1);
  endtask

  task automatic test_backpressure;
    int w, cyc, bad;
    issue(0, OP_MUL, 32'd5, 32'd6, w);
    set_req(1, OP_MULHU, 32'h8000_0000, 32'd4);
    wait_rsp(0, cyc);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL bp_latency: got %0d expected 7", cyc); end
    bad = 0;
    repeat (5) begin
      if (rsp_valid !== 2'b01 || rsp_result !== 32'd30 || req_ready !== 2'b00) bad++;
      @(posedge clk); #1;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
    consume(0);
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_next_grant: got %b expected 10", req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(1, cyc);
    n_checks++; if (rsp_result !== 32'd2) begin n_fail++; $display("FAIL bp_req1_result: got %h expected 00000002", rsp_result); end
    consume(1);
  endtask

  task automatic test_reset_mid;
    int w, cyc;
    // Leave the pointer at 0 so an un-reset arbiter would prefer req1
    issue(0, OP_MUL, 32'd1, 32'd1, w);
    wait_rsp(0, cyc);
    consume(0);
    issue(0, OP_DIVU, 32'd1000, 32'd7, w);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    n_checks++; if ({busy, md_valid, req_ready, rsp_valid} !== 6'd0) begin n_fail++; $display("FAIL midreset_ctrl: got %b expected 000000", {busy, md_valid, req_ready, rsp_valid}); end
    n_checks++; if ({md_op, md_num1, md_num2, rsp_result} !== 99'd0) begin n_fail++; $display("FAIL midreset_data: got %h expected 0", {md_op, md_num1, md_num2, rsp_result}); end
    @(posedge clk); #1;
    rst_n = 1;
    set_req(0, OP_DIVU, 32'd1000, 32'd7);
    set_req(1, OP_MUL, 32'd9, 32'd9);
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midreset_first_grant: got %b expected 01", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(0, cyc);
    n_checks++; if (rsp_result !== 32'd142) begin n_fail++; $display("FAIL midreset_divu_result: got %h expected 0000008e", rsp_result); end
    consume(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_single_mul();
    test_contention();
    test_div_zero();
    test_flush_run();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
